qif_neuron_scheduler: RTL and testbench

QIF_NEURON_SCHEDULER -- requirements
Module: qif_neuron_scheduler

---
 rtl/qif_pkg.sv | 20 ++
 rtl/qif_update_core.sv | 45 ++++
 rtl/qif_neuron_scheduler.sv | 124 ++++++++++++
 tb/tb_qif_neuron_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qif_pkg.sv
// Shared types and default parameters for the time-multiplexed QIF neuron array.
package qif_pkg;

    localparam int                 N_NEURONS_DEF = 8;
    localparam logic signed [7:0]  V_RESET_DEF   = -8'sd20;
    localparam logic signed [7:0]  V_PEAK_DEF    = 8'sd50;
    localparam int                 A_SHIFT_DEF   = 6;

    typedef logic signed [7:0] mem_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        WRITE,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/qif_update_core.sv
// Combinational QIF membrane update: v + (v^2 >> A_SHIFT) + i, with spike detect and saturation.
module qif_update_core
    import qif_pkg::*;
#(
    parameter logic signed [7:0] V_RESET = V_RESET_DEF,
    parameter logic signed [7:0] V_PEAK  = V_PEAK_DEF,
    parameter int                A_SHIFT = A_SHIFT_DEF
) (
    input  mem_t v,
    input  mem_t i,
    output mem_t v_next,
    output logic fired
);

    localparam logic signed [17:0] SAT_MAX = 18'sd127;
    localparam logic signed [17:0] SAT_MIN = -18'sd128;

    logic signed [15:0] v_wide;
    logic        [15:0] v_sq;
    logic signed [17:0] sum;
    logic signed [17:0] peak_wide;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        v_next    = '0;
        fired     = 1'b0;
        v_wide    = {{8{v[7]}}, v};
        // |v| <= 128, so the square always fits 16 bits and is non-negative.
        v_sq      = v_wide * v_wide;
        sum       = {{10{v[7]}}, v} + {2'b00, v_sq >> A_SHIFT} + {{10{i[7]}}, i};
        peak_wide = {{10{V_PEAK[7]}}, V_PEAK};

        if (sum >= peak_wide) begin
            fired  = 1'b1;
            v_next = V_RESET;
        end else if (sum > SAT_MAX) begin
            v_next = 8'sd127;
        end else if (sum < SAT_MIN) begin
            v_next = -8'sd128;
        end else begin
            v_next = sum[7:0];
        end
    end

endmodule

// File: rtl/qif_neuron_scheduler.sv
// Sweeps N_NEURONS QIF neurons through one shared update core, emitting spike events with backpressure.
module qif_neuron_scheduler
    import qif_pkg::*;
#(
    parameter int                N_NEURONS = N_NEURONS_DEF,
    parameter logic signed [7:0] V_RESET   = V_RESET_DEF,
    parameter logic signed [7:0] V_PEAK    = V_PEAK_DEF,
    parameter int                A_SHIFT   = A_SHIFT_DEF,
    localparam int               IW        = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_addr,
    input  logic signed [7:0]    wr_data,
    input  logic [IW-1:0]        rd_addr,
    output logic signed [7:0]    rd_data,
    output logic                 spike_valid,
    output logic [IW-1:0]        spike_id,
    input  logic                 spike_ready
);

    localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    mem_t          v_mem [N_NEURONS];
    mem_t          i_mem [N_NEURONS];
    mem_t          v_op, i_op, v_res;
    logic          fired_r;
    mem_t          core_v_next;
    logic          core_fired;

    qif_update_core #(
        .V_RESET (V_RESET),
        .V_PEAK  (V_PEAK),
        .A_SHIFT (A_SHIFT)
    ) u_core (
        .v      (v_op),
        .i      (i_op),
        .v_next (core_v_next),
        .fired  (core_fired)
    );

    // NOTE: the V and I arrays are deliberately reset (architectural state must read 0), which keeps them in flops rather than RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            v_op    <= '0;
            i_op    <= '0;
            v_res   <= '0;
            fired_r <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                v_mem[n] <= '0;
                i_mem[n] <= '0;
            end
        end else begin
            state <= state_nx;
            // Host writes land only while idle; a write alongside start is seen by the sweep.
            if (state == IDLE && wr_en)
                i_mem[wr_addr] <= wr_data;
            case (state)
                IDLE:    if (start) idx <= '0;
                LOAD: begin
                    v_op <= v_mem[idx];
                    i_op <= i_mem[idx];
                end
                COMPUTE: begin
                    v_res   <= core_v_next;
                    fired_r <= core_fired;
                end
                WRITE: begin
                    v_mem[idx] <= v_res;
                    if (!fired_r && idx != LAST) idx <= idx + 1'b1;
                end
                EMIT:    if (spike_ready && idx != LAST) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        done        = 1'b0;
        spike_valid = 1'b0;
        spike_id    = '0;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD: begin
                busy     = 1'b1;
                state_nx = COMPUTE;
            end
            COMPUTE: begin
                busy     = 1'b1;
                state_nx = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (fired_r)          state_nx = EMIT;
                else if (idx == LAST) state_nx = DONE;
                else                  state_nx = LOAD;
            end
            EMIT: begin
                busy        = 1'b1;
                spike_valid = 1'b1;
                spike_id    = idx;
                if (spike_ready) state_nx = (idx == LAST) ? DONE : LOAD;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rd_data = v_mem[rd_addr];

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Directed bench for qif_neuron_scheduler: arithmetic, saturation, spike backpressure, busy filtering, reset abort.
module tb_qif_neuron_scheduler;

    localparam int N  = 8;
    localparam int IW = 3;

    logic                clk = 1'b0;
    logic                reset, start, wr_en, spike_ready;
    logic [IW-1:0]       wr_addr, rd_addr;
    logic signed [7:0]   wr_data;
    logic signed [7:0]   rd_data;
    logic                busy, done, spike_valid;
    logic [IW-1:0]       spike_id;

    int n_checks = 0;
    int n_fails  = 0;

    qif_neuron_scheduler #(.N_NEURONS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .spike_valid (spike_valid),
        .spike_id    (spike_id),
        .spike_ready (spike_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_v(input int addr, input int exp);
        rd_addr = IW'(addr);
        #1;
        check($sformatf("V[%0d]", addr), int'(rd_data), exp);
    endtask

    task automatic write_i(input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = IW'(addr);
        wr_data = 8'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Runs one sweep from a negedge; cycles counts from the start-sampling cycle to the done cycle.
    task automatic run_sweep(input int hold, input bit junk, input bit wr_start,
                             input int wr_a, input int wr_d,
                             output int cycles, output int n_spk,
                             output int id0, output int id1);
        bit in_emit;
        int w, cur_id;
        @(negedge clk);
        start = 1'b1;
        if (wr_start) begin
            wr_en   = 1'b1;
            wr_addr = IW'(wr_a);
            wr_data = 8'(wr_d);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        cycles = -1; n_spk = 0; id0 = -1; id1 = -1;
        in_emit = 1'b0; w = 0; cur_id = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_after_start", busy, 1);
            if (junk && c == 6) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'sd99;
            end else if (junk && c == 7) begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (spike_valid) begin
                if (!in_emit) begin
                    in_emit = 1'b1; w = 0; cur_id = int'(spike_id);
                    if (n_spk == 0) id0 = cur_id; else id1 = cur_id;
                    n_spk++;
                end else begin
                    check("spike_id_stable", int'(spike_id), cur_id);
                end
                spike_ready = (w >= ((n_spk == 1) ? hold : 0));
                w++;
            end else begin
                in_emit = 1'b0;
                spike_ready = 1'b0;
            end
            if (done) begin
                cycles = c;
                check("busy_low_in_done", busy, 0);
                break;
            end
        end
        spike_ready = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int cyc, nsp, i0, i1, extra;
        reset = 1'b1; start = 1'b0; wr_en = 1'b0; spike_ready = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_spike_valid", spike_valid, 0);
        check("reset_spike_id", int'(spike_id), 0);
        check_v(0, 0);
        reset = 1'b0;

        // Sweep 1: V[1] <- 0 + 0 + 10.
        write_i(1, 10);
        run_sweep(0, 1'b0, 1'b0, 0, 0, cyc, nsp, i0, i1);
        check("s1_done_cycle", cyc, 3 * N + 1);
        check("s1_spikes", nsp, 0);
        check_v(0, 0);
        check_v(1, 10);

        // Sweep 2: I[0]=10 beforehand, I[1]=0 written together with start.
        write_i(0, 10);
        run_sweep(0, 1'b0, 1'b1, 1, 0, cyc, nsp, i0, i1);
        check("s2_done_cycle", cyc, 25);
        check("s2_spikes", nsp, 0);
        check_v(0, 10);
        check_v(1, 11);
        check_v(2, 0);

        // Sweep 3: load V[2]=-10, V[3]=40, V[4]=-100 from zero membranes.
        write_i(0, 0);
        write_i(2, -10);
        write_i(3, 40);
        write_i(4, -100);
        run_sweep(0, 1'b0, 1'b0, 0, 0, cyc, nsp, i0, i1);
        check("s3_spikes", nsp, 0);
        check_v(0, 11);
        check_v(1, 12);
        check_v(2, -10);
        check_v(3, 40);
        check_v(4, -100);

        // Sweep 4: saturation on 2, spikes on 3 (held 4 cycles) and 4, busy-time start/write ignored.
        write_i(2, -128);
        write_i(4, 0);
        run_sweep(4, 1'b1, 1'b1, 3, 5, cyc, nsp, i0, i1);
        check("s4_done_cycle", cyc, 25 + 5 + 1);
        check("s4_spikes", nsp, 2);
        check("s4_spike_id0", i0, 3);
        check("s4_spike_id1", i1, 4);
        check_v(0, 12);
        check_v(1, 14);
        check_v(2, -128);
        check_v(3, -20);
        check_v(4, -20);
        check_v(5, 0);
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("s4_no_second_sweep", extra, 0);

        // Sweep 5: neuron 6 fires; reset lands while the spike waits in EMIT.
        write_i(6, 60);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (spike_valid) break;
            @(negedge clk);
        end
        check("s5_spike_valid", spike_valid, 1);
        check("s5_spike_id", int'(spike_id), 6);
        check_v(0, 14);
        check_v(1, 17);
        check_v(2, 0);
        check_v(3, -9);
        check_v(5, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_spike_id", int'(spike_id), 0);
        for (int a = 0; a < N; a++) check_v(a, 0);
        reset = 1'b0;
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || spike_valid || busy) extra++;
        end
        check("rst_no_followup", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
